// File: rtl/hit_extender.sv
// Ungapped X-drop seed extension: captures a seed on hit, extends right then left, reports the best HSP.
// Latency: DONE (stop/outValid/score/positions valid) occurs 1+R+L cycles after the capture edge.
// Backpressure: hit is held by the detector until the one-cycle stop pulse; hit is ignored while busy.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   query, queryValid     256x2b query word and its load strobe (loads in any state, not reset)
//   dataBase              256x2b database block, sampled only at capture
//   hit, locationQ,       seed request plus seed bit offsets in query / database block (even)
//   ShiftNo
//   stop, outValid        one-cycle acknowledge and HSP strobe (score >= THRESH)
//   score, qStart..dEnd   signed best score and inclusive nucleotide ranges of the HSP
//   busy                  high whenever the extender is not idle
module hit_extender #(
  parameter int XDROP    = 10,
  parameter int THRESH   = 20,
  parameter int MATCH    = 1,
  parameter int MISMATCH = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [511:0]        query,
  input  logic                queryValid,
  input  logic [511:0]        dataBase,
  input  logic                hit,
  input  logic [8:0]          locationQ,
  input  logic [8:0]          ShiftNo,
  output logic                stop,
  output logic                outValid,
  output logic signed [11:0]  score,
  output logic [7:0]          qStart,
  output logic [7:0]          qEnd,
  output logic [7:0]          dStart,
  output logic [7:0]          dEnd,
  output logic                busy
);

  localparam logic signed [11:0] XDROP_S    = 12'(XDROP);
  localparam logic signed [11:0] THRESH_S   = 12'(THRESH);
  localparam logic signed [11:0] MATCH_S    = 12'(MATCH);
  localparam logic signed [11:0] MISMATCH_S = 12'(MISMATCH);
  localparam logic signed [11:0] SEED_S     = 12'sd11;

  typedef enum logic [1:0] {IDLE, EXT_R, EXT_L, DONE} state_t;

  state_t             state_q;
  logic [511:0]       query_q;
  logic [511:0]       db_q;
  logic [7:0]         qpos_q, dpos_q;
  logic signed [11:0] run_q, best_q;
  logic [7:0]         roff_q, loff_q, bestr_q, bestl_q;

  logic               stop_q, ov_q;
  logic signed [11:0] score_q;
  logic [7:0]         qstart_q, qend_q, dstart_q, dend_q;

  // Per-step combinational values
  logic [9:0]         r_i, r_j;
  logic [8:0]         l_i, l_j;
  logic               r_oob, l_oob;
  logic [7:0]         qi, di;
  logic [1:0]         q_nt, d_nt;
  logic signed [11:0] run_d, best_d, fin_best_d;
  logic               gain, drop;
  logic [7:0]         off_d, fin_bestl_d;

  // Only the nucleotide index is meaningful; bit 0 of the bit offsets is always zero.
  logic unused_lsb;
  assign unused_lsb = locationQ[0] ^ ShiftNo[0];

  always_comb begin
    r_i   = {2'b00, qpos_q} + 10'd11 + {2'b00, roff_q};
    r_j   = {2'b00, dpos_q} + 10'd11 + {2'b00, roff_q};
    r_oob = (r_i > 10'd255) || (r_j > 10'd255);
    // 9-bit signed: bit 8 set means the left index ran below nucleotide 0
    l_i   = {1'b0, qpos_q} - 9'd1 - {1'b0, loff_q};
    l_j   = {1'b0, dpos_q} - 9'd1 - {1'b0, loff_q};
    l_oob = l_i[8] | l_j[8];

    qi    = (state_q == EXT_L) ? l_i[7:0] : r_i[7:0];
    di    = (state_q == EXT_L) ? l_j[7:0] : r_j[7:0];
    q_nt  = query_q[{qi, 1'b0} +: 2];
    d_nt  = db_q[{di, 1'b0} +: 2];

    run_d  = (q_nt == d_nt) ? (run_q + MATCH_S) : (run_q - MISMATCH_S);
    gain   = run_d > best_q;   // strict: ties keep the earlier best
    best_d = gain ? run_d : best_q;
    drop   = (best_d - run_d) >= XDROP_S;
    off_d  = ((state_q == EXT_L) ? loff_q : roff_q) + 8'd1;

    // Values that become the result if the left extension ends this cycle
    fin_best_d  = l_oob ? best_q : best_d;
    fin_bestl_d = (!l_oob && gain) ? off_d : bestl_q;
  end

  always_ff @(posedge clk) begin
    if (queryValid) query_q <= query;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      db_q     <= '0;
      qpos_q   <= '0;
      dpos_q   <= '0;
      run_q    <= '0;
      best_q   <= '0;
      roff_q   <= '0;
      loff_q   <= '0;
      bestr_q  <= '0;
      bestl_q  <= '0;
      stop_q   <= 1'b0;
      ov_q     <= 1'b0;
      score_q  <= '0;
      qstart_q <= '0;
      qend_q   <= '0;
      dstart_q <= '0;
      dend_q   <= '0;
    end else begin
      stop_q <= 1'b0;
      ov_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            qpos_q  <= locationQ[8:1];
            dpos_q  <= ShiftNo[8:1];
            db_q    <= dataBase;
            run_q   <= SEED_S;
            best_q  <= SEED_S;
            roff_q  <= '0;
            loff_q  <= '0;
            bestr_q <= '0;
            bestl_q <= '0;
            state_q <= EXT_R;
          end
        end
        EXT_R: begin
          if (r_oob) begin
            run_q   <= best_q;
            state_q <= EXT_L;
          end else begin
            best_q <= best_d;
            roff_q <= off_d;
            if (gain) bestr_q <= off_d;
            if (drop) begin
              run_q   <= best_d;   // left extension restarts from the best right score
              state_q <= EXT_L;
            end else begin
              run_q <= run_d;
            end
          end
        end
        EXT_L: begin
          if (!l_oob) begin
            run_q  <= run_d;
            best_q <= best_d;
            loff_q <= off_d;
            if (gain) bestl_q <= off_d;
          end
          if (l_oob || drop) begin
            state_q  <= DONE;
            stop_q   <= 1'b1;
            ov_q     <= fin_best_d >= THRESH_S;
            score_q  <= fin_best_d;
            qstart_q <= qpos_q - fin_bestl_d;
            qend_q   <= qpos_q + 8'd10 + bestr_q;
            dstart_q <= dpos_q - fin_bestl_d;
            dend_q   <= dpos_q + 8'd10 + bestr_q;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign stop     = stop_q;
  assign outValid = ov_q;
  assign score    = score_q;
  assign qStart   = qstart_q;
  assign qEnd     = qend_q;
  assign dStart   = dstart_q;
  assign dEnd     = dend_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_hit_extender.sv
module tb_hit_extender;

  localparam int XDROP    = 10;
  localparam int THRESH   = 20;
  localparam int MATCH    = 1;
  localparam int MISMATCH = 3;

  logic               clk;
  logic               rst;
  logic [511:0]       query;
  logic               queryValid;
  logic [511:0]       dataBase;
  logic               hit;
  logic [8:0]         locationQ;
  logic [8:0]         ShiftNo;
  logic               stop;
  logic               outValid;
  logic signed [11:0] score;
  logic [7:0]         qStart, qEnd, dStart, dEnd;
  logic               busy;

  int errors = 0;
  int checks = 0;

  // Observations captured by do_hit
  logic signed [11:0] o_score;
  logic [7:0]         o_qs, o_qe, o_ds, o_de;
  logic               o_ov, o_stop2, o_ov2, o_busy2;

  hit_extender #(.XDROP(XDROP), .THRESH(THRESH), .MATCH(MATCH), .MISMATCH(MISMATCH)) dut (
    .clk(clk), .rst(rst), .query(query), .queryValid(queryValid), .dataBase(dataBase),
    .hit(hit), .locationQ(locationQ), .ShiftNo(ShiftNo), .stop(stop), .outValid(outValid),
    .score(score), .qStart(qStart), .qEnd(qEnd), .dStart(dStart), .dEnd(dEnd), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: scan the sequences as plain arrays, right then left, with X-drop.
  function automatic void ref_ext(input logic [511:0] q, input logic [511:0] d,
                                  input int qp, input int dp,
                                  output int sc, output int qs, output int qe,
                                  output int ds, output int de, output int lat);
    int run, best, br, bl, rc, lc, i, j;
    run = 11; best = 11; br = 0; bl = 0; rc = 0; lc = 0;
    for (int s = 0; s < 300; s++) begin
      rc++;
      i = qp + 11 + s;
      j = dp + 11 + s;
      if (i > 255 || j > 255) break;
      run += (q[2*i +: 2] == d[2*j +: 2]) ? MATCH : -MISMATCH;
      if (run > best) begin best = run; br = s + 1; end
      if (best - run >= XDROP) break;
    end
    run = best;
    for (int s = 0; s < 300; s++) begin
      lc++;
      i = qp - 1 - s;
      j = dp - 1 - s;
      if (i < 0 || j < 0) break;
      run += (q[2*i +: 2] == d[2*j +: 2]) ? MATCH : -MISMATCH;
      if (run > best) begin best = run; bl = s + 1; end
      if (best - run >= XDROP) break;
    end
    sc = best; qs = qp - bl; qe = qp + 10 + br; ds = dp - bl; de = dp + 10 + br;
    lat = 1 + rc + lc;
  endfunction

  // Drives one seed request like the detector would; cyc counts cycles from capture (capture cycle = 1).
  task automatic do_hit(input logic [511:0] q, input logic [511:0] d, input int qp, input int dp,
                        input bit ldq, output int cyc, output bit to);
    if (ldq) begin
      query = q; queryValid = 1'b1;
      @(posedge clk); #1;
      queryValid = 1'b0;
    end
    dataBase = d; locationQ = 9'(qp * 2); ShiftNo = 9'(dp * 2); hit = 1'b1;
    cyc = 0; to = 1'b1;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (k == 0) dataBase = ~d;   // post-capture changes must be ignored
      if (stop) begin to = 1'b0; break; end
    end
    o_score = score; o_qs = qStart; o_qe = qEnd; o_ds = dStart; o_de = dEnd; o_ov = outValid;
    hit = 1'b0;
    @(posedge clk); #1;
    o_stop2 = stop; o_ov2 = outValid; o_busy2 = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; hit = 1'b1; locationQ = 9'd20; ShiftNo = 9'd40; dataBase = '0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({stop, outValid, busy} !== 3'b000) begin
        errors++; $display("FAIL reset_flags[%0d]: stop/ov/busy=%b want 000", c, {stop, outValid, busy});
      end
      checks++;
      if ({score, qStart, qEnd, dStart, dEnd} !== 44'd0) begin
        errors++; $display("FAIL reset_values[%0d]: score=%0d pos=%0d/%0d/%0d/%0d want 0", c,
                            score, qStart, qEnd, dStart, dEnd);
      end
    end
    hit = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_no_capture: busy=%b want 0", busy); end
  endtask

  task automatic test_full_match();
    int cyc; bit to;
    do_hit('0, '0, 100, 100, 1'b1, cyc, to);
    checks++;
    if (to || cyc != 248) begin errors++; $display("FAIL full_latency: cycle=%0d timeout=%0d want 248", cyc, to); end
    checks++;
    if (o_score !== 12'sd256) begin errors++; $display("FAIL full_score: got %0d want 256", o_score); end
    checks++;
    if ({o_qs, o_qe, o_ds, o_de} !== {8'd0, 8'd255, 8'd0, 8'd255}) begin
      errors++; $display("FAIL full_pos: got %0d %0d %0d %0d want 0 255 0 255", o_qs, o_qe, o_ds, o_de);
    end
    checks++;
    if (o_ov !== 1'b1) begin errors++; $display("FAIL full_outValid: got %b want 1", o_ov); end
    checks++;
    if ({o_stop2, o_ov2, o_busy2} !== 3'b000) begin
      errors++; $display("FAIL full_pulse: after DONE stop/ov/busy=%b want 000", {o_stop2, o_ov2, o_busy2});
    end
  endtask

  task automatic test_xdrop();
    int cyc; bit to;
    logic [511:0] d;
    for (int n = 0; n < 256; n++) d[2*n +: 2] = (n >= 50 && n <= 60) ? 2'b00 : 2'b01;
    do_hit('0, d, 50, 50, 1'b1, cyc, to);
    checks++;
    if (to || cyc != 9) begin errors++; $display("FAIL xdrop_latency: cycle=%0d timeout=%0d want 9", cyc, to); end
    checks++;
    if (o_score !== 12'sd11) begin errors++; $display("FAIL xdrop_score: got %0d want 11", o_score); end
    checks++;
    if ({o_qs, o_qe, o_ds, o_de} !== {8'd50, 8'd60, 8'd50, 8'd60}) begin
      errors++; $display("FAIL xdrop_pos: got %0d %0d %0d %0d want 50 60 50 60", o_qs, o_qe, o_ds, o_de);
    end
    checks++;
    if (o_ov !== 1'b0) begin errors++; $display("FAIL xdrop_outValid: got %b want 0", o_ov); end
  endtask

  task automatic test_edge_seed();
    int cyc; bit to;
    logic [511:0] q;
    for (int w = 0; w < 16; w++) q[32*w +: 32] = $urandom();
    do_hit(q, q, 245, 0, 1'b1, cyc, to);
    checks++;
    if (to || cyc != 3) begin errors++; $display("FAIL edge_latency: cycle=%0d timeout=%0d want 3", cyc, to); end
    checks++;
    if (o_score !== 12'sd11) begin errors++; $display("FAIL edge_score: got %0d want 11", o_score); end
    checks++;
    if ({o_qs, o_qe, o_ds, o_de} !== {8'd245, 8'd255, 8'd0, 8'd10}) begin
      errors++; $display("FAIL edge_pos: got %0d %0d %0d %0d want 245 255 0 10", o_qs, o_qe, o_ds, o_de);
    end
    checks++;
    if (o_ov !== 1'b0) begin errors++; $display("FAIL edge_outValid: got %b want 0", o_ov); end
  endtask

  task automatic test_mid_reset();
    int cyc; bit to;
    int spurious;
    query = '0; queryValid = 1'b1;
    @(posedge clk); #1;
    queryValid = 1'b0;
    dataBase = '0; locationQ = 9'd200; ShiftNo = 9'd200; hit = 1'b1;
    for (int k = 1; k < 50; k++) begin @(posedge clk); #1; end
    rst = 1'b1; hit = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({stop, outValid, busy} !== 3'b000) begin
      errors++; $display("FAIL midrst_flags: stop/ov/busy=%b want 000", {stop, outValid, busy});
    end
    checks++;
    if ({score, qStart, qEnd, dStart, dEnd} !== 44'd0) begin
      errors++; $display("FAIL midrst_values: score=%0d pos=%0d/%0d/%0d/%0d want 0", score, qStart, qEnd, dStart, dEnd);
    end
    spurious = 0;
    for (int k = 0; k < 250; k++) begin
      @(posedge clk); #1;
      if (stop || busy) spurious++;
    end
    checks++;
    if (spurious != 0) begin errors++; $display("FAIL midrst_no_stop: active cycles=%0d want 0", spurious); end
    do_hit('0, '0, 100, 100, 1'b0, cyc, to);
    checks++;
    if (to || cyc != 248 || o_score !== 12'sd256 || o_qs !== 8'd0 || o_qe !== 8'd255) begin
      errors++; $display("FAIL midrst_rerun: cycle=%0d score=%0d q=%0d..%0d want 248 256 0..255",
                          cyc, o_score, o_qs, o_qe);
    end
  endtask

  task automatic make_pair(output logic [511:0] q, output logic [511:0] d,
                           output int qp, output int dp);
    int m;
    for (int w = 0; w < 16; w++) q[32*w +: 32] = $urandom();
    qp = int'($urandom_range(0, 245));
    dp = int'($urandom_range(0, 245));
    for (int n = 0; n < 256; n++) begin
      m = n - dp + qp;
      if (m >= 0 && m <= 255 && $urandom_range(0, 11) != 0) d[2*n +: 2] = q[2*m +: 2];
      else d[2*n +: 2] = 2'($urandom());
    end
    for (int s = 0; s < 11; s++) d[2*(dp+s) +: 2] = q[2*(qp+s) +: 2];
  endtask

  task automatic test_back_to_back();
    logic [511:0] q, d1, d2;
    int qp1, dp1, qp2, dp2, cyc, sc, qs, qe, ds, de, lat;
    bit to;
    logic [511:0] qtmp;
    make_pair(q, d1, qp1, dp1);
    do_hit(q, d1, qp1, dp1, 1'b1, cyc, to);
    ref_ext(q, d1, qp1, dp1, sc, qs, qe, ds, de, lat);
    checks++;
    if (to || cyc != lat || {o_score, o_qs, o_qe, o_ds, o_de, o_ov} !==
        {12'(sc), 8'(qs), 8'(qe), 8'(ds), 8'(de), (sc >= THRESH)}) begin
      errors++; $display("FAIL b2b_first: cyc=%0d score=%0d q=%0d..%0d d=%0d..%0d ov=%b want cyc=%0d score=%0d q=%0d..%0d d=%0d..%0d",
                          cyc, o_score, o_qs, o_qe, o_ds, o_de, o_ov, lat, sc, qs, qe, ds, de);
    end
    // Second hit raised in the IDLE cycle right after stop falls, same query register.
    make_pair(qtmp, d2, qp2, dp2);
    for (int s = 0; s < 11; s++) d2[2*(dp2+s) +: 2] = q[2*(qp2+s) +: 2];
    do_hit(q, d2, qp2, dp2, 1'b0, cyc, to);
    ref_ext(q, d2, qp2, dp2, sc, qs, qe, ds, de, lat);
    checks++;
    if (to || cyc != lat || {o_score, o_qs, o_qe, o_ds, o_de, o_ov} !==
        {12'(sc), 8'(qs), 8'(qe), 8'(ds), 8'(de), (sc >= THRESH)}) begin
      errors++; $display("FAIL b2b_second: cyc=%0d score=%0d q=%0d..%0d d=%0d..%0d ov=%b want cyc=%0d score=%0d q=%0d..%0d d=%0d..%0d",
                          cyc, o_score, o_qs, o_qe, o_ds, o_de, o_ov, lat, sc, qs, qe, ds, de);
    end
    checks++;
    if ({o_stop2, o_busy2} !== 2'b00) begin
      errors++; $display("FAIL b2b_idle: stop/busy=%b want 00", {o_stop2, o_busy2});
    end
  endtask

  task automatic test_random();
    logic [511:0] q, d;
    int qp, dp, cyc, sc, qs, qe, ds, de, lat;
    bit to;
    for (int t = 0; t < 24; t++) begin
      make_pair(q, d, qp, dp);
      do_hit(q, d, qp, dp, 1'b1, cyc, to);
      ref_ext(q, d, qp, dp, sc, qs, qe, ds, de, lat);
      checks++;
      if (to || cyc != lat) begin
        errors++; $display("FAIL rand_latency[%0d]: cycle=%0d timeout=%0d want %0d", t, cyc, to, lat);
      end
      checks++;
      if ({o_score, o_qs, o_qe, o_ds, o_de} !== {12'(sc), 8'(qs), 8'(qe), 8'(ds), 8'(de)}) begin
        errors++; $display("FAIL rand_result[%0d]: score=%0d q=%0d..%0d d=%0d..%0d want score=%0d q=%0d..%0d d=%0d..%0d",
                            t, o_score, o_qs, o_qe, o_ds, o_de, sc, qs, qe, ds, de);
      end
      checks++;
      if (o_ov !== (sc >= THRESH) || {o_stop2, o_ov2} !== 2'b00) begin
        errors++; $display("FAIL rand_strobes[%0d]: ov=%b stop_after=%b ov_after=%b want ov=%b then 0 0",
                            t, o_ov, o_stop2, o_ov2, (sc >= THRESH));
      end
    end
  endtask

  initial begin
    rst = 1'b1; hit = 1'b0; query = '0; queryValid = 1'b0; dataBase = '0;
    locationQ = '0; ShiftNo = '0;
    test_reset();
    test_full_match();
    test_xdrop();
    test_edge_seed();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
